// File: rtl/w_icons_stim_seq_pkg.sv
// Shared types and default sizes for the stimulation sequencer.
// Latency: n/a. Backpressure: n/a.
// Optional feature macro: W_ICONS_STIM_SEQ_REPEAT_EN.
package w_icons_stim_seq_pkg;

    localparam int NUM_CH_DFLT     = 8;
    localparam int STIM_CNT_W_DFLT = 12;
    localparam int DIS_CNT_W_DFLT  = 8;

    typedef enum logic [2:0] {
        W_ICONS_SEQ_IDLE  = 3'd0,
        W_ICONS_SEQ_ARB   = 3'd1,
        W_ICONS_SEQ_STIM  = 3'd2,
        W_ICONS_SEQ_DISCH = 3'd3,
        W_ICONS_SEQ_DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/w_icons_stim_seq_if.sv
// Control/status bundle between the stim controller and the sequencer.
// Latency: n/a (wires only). Backpressure: none; ticks and strobes are single-cycle.
// repeat_i exists only when W_ICONS_STIM_SEQ_REPEAT_EN is defined.
interface w_icons_stim_seq_if
    import w_icons_stim_seq_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DFLT,
    parameter int STIM_CNT_W = STIM_CNT_W_DFLT,
    parameter int DIS_CNT_W  = DIS_CNT_W_DFLT
);
    logic                  start_i;
    logic                  abort_i;
    logic [NUM_CH-1:0]     ch_req_i;
    logic [STIM_CNT_W-1:0] stim_len_i;
    logic [DIS_CNT_W-1:0]  dis_len_i;
    logic                  stim_tick_i;
    logic                  dis_tick_i;
`ifdef W_ICONS_STIM_SEQ_REPEAT_EN
    logic                  repeat_i;
`endif
    logic                  en_clk_stim_o;
    logic                  en_clk_discharge_o;
    logic [NUM_CH-1:0]     ch_sel_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;

    modport master (
`ifdef W_ICONS_STIM_SEQ_REPEAT_EN
        output repeat_i,
`endif
        output start_i, abort_i, ch_req_i, stim_len_i, dis_len_i, stim_tick_i, dis_tick_i,
        input  en_clk_stim_o, en_clk_discharge_o, ch_sel_o, busy_o, done_o, err_o
    );

    modport slave (
`ifdef W_ICONS_STIM_SEQ_REPEAT_EN
        input  repeat_i,
`endif
        input  start_i, abort_i, ch_req_i, stim_len_i, dis_len_i, stim_tick_i, dis_tick_i,
        output en_clk_stim_o, en_clk_discharge_o, ch_sel_o, busy_o, done_o, err_o
    );

endinterface

// File: rtl/w_icons_stim_seq_rr_arb.sv
// Round-robin pick of the first pending channel strictly after last_idx, wrapping.
// Latency: combinational. Backpressure: none.
// Not affected by W_ICONS_STIM_SEQ_REPEAT_EN.
module w_icons_rr_arb
    import w_icons_stim_seq_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DFLT,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pend,
    input  logic [IDX_W-1:0]  last_idx,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_vld
);

    logic [IDX_W-1:0] cand;

    // Scan farthest-first so the nearest candidate after last_idx overwrites and wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = IDX_W'((int'(last_idx) + i) % NUM_CH);
            if (pend[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_vld   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/w_icons_stim_seq.sv
// Round-robin stim/discharge sequencer: serves a snapshot of requesting channels one at a time.
// Latency: ARB one cycle after start, STIM the next; all outputs registered from next state.
// Backpressure: none; phases advance on tick strobes. W_ICONS_STIM_SEQ_REPEAT_EN adds auto-restart.
module w_icons_stim_seq
    import w_icons_stim_seq_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DFLT,
    parameter int STIM_CNT_W = STIM_CNT_W_DFLT,
    parameter int DIS_CNT_W  = DIS_CNT_W_DFLT
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    w_icons_stim_seq_if.slave seq_if
);

    localparam int IDX_W = $clog2(NUM_CH);

    seq_state_e            state_q, state_d;
    logic [NUM_CH-1:0]     pend_q, pend_d;
    logic [NUM_CH-1:0]     ch_sel_q, ch_sel_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic                  err_q, err_d;
    logic [STIM_CNT_W-1:0] stim_len_q, stim_len_d, stim_cnt_q, stim_cnt_d;
    logic [DIS_CNT_W-1:0]  dis_len_q, dis_len_d, dis_cnt_q, dis_cnt_d;
    logic                  en_stim_q, en_dis_q, busy_q, done_q;

    logic [NUM_CH-1:0]     arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_vld;

    logic [STIM_CNT_W:0]   stim_cnt_p1;
    logic [DIS_CNT_W:0]    dis_cnt_p1;
    logic                  stim_match, dis_match;

    w_icons_rr_arb #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
        .pend      (pend_q),
        .last_idx  (last_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    // A tick that completes the count ends the phase on this edge.
    assign stim_cnt_p1 = {1'b0, stim_cnt_q} + {{STIM_CNT_W{1'b0}}, 1'b1};
    assign dis_cnt_p1  = {1'b0, dis_cnt_q} + {{DIS_CNT_W{1'b0}}, 1'b1};
    assign stim_match  = (stim_cnt_q == stim_len_q) ||
                         (seq_if.stim_tick_i && (stim_cnt_p1 == {1'b0, stim_len_q}));
    assign dis_match   = (dis_cnt_q == dis_len_q) ||
                         (seq_if.dis_tick_i && (dis_cnt_p1 == {1'b0, dis_len_q}));

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        ch_sel_d   = ch_sel_q;
        last_d     = last_q;
        err_d      = err_q;
        stim_len_d = stim_len_q;
        dis_len_d  = dis_len_q;
        stim_cnt_d = '0;
        dis_cnt_d  = '0;
        case (state_q)
            W_ICONS_SEQ_IDLE: begin
                if (seq_if.start_i) begin
                    pend_d     = seq_if.ch_req_i;
                    stim_len_d = seq_if.stim_len_i;
                    dis_len_d  = seq_if.dis_len_i;
                    err_d      = 1'b0;
                    state_d    = W_ICONS_SEQ_ARB;
                end
            end
            W_ICONS_SEQ_ARB: begin
                // Once err is set the mask is already empty, so a held abort falls through to DONE.
                if (seq_if.abort_i && !err_q) begin
                    err_d   = 1'b1;
                    pend_d  = '0;
                    state_d = W_ICONS_SEQ_DISCH;
                end else if (!arb_vld) begin
                    ch_sel_d = '0;
                    state_d  = W_ICONS_SEQ_DONE;
                end else begin
                    ch_sel_d = arb_grant;
                    last_d   = arb_idx;
                    pend_d   = pend_q & ~arb_grant;
                    state_d  = W_ICONS_SEQ_STIM;
                end
            end
            W_ICONS_SEQ_STIM: begin
                stim_cnt_d = (seq_if.stim_tick_i && (stim_cnt_q != '1)) ?
                             stim_cnt_p1[STIM_CNT_W-1:0] : stim_cnt_q;
                if (seq_if.abort_i) begin
                    err_d   = 1'b1;
                    pend_d  = '0;
                    state_d = W_ICONS_SEQ_DISCH;
                end else if (stim_match) begin
                    state_d = W_ICONS_SEQ_DISCH;
                end
            end
            W_ICONS_SEQ_DISCH: begin
                dis_cnt_d = (seq_if.dis_tick_i && (dis_cnt_q != '1)) ?
                            dis_cnt_p1[DIS_CNT_W-1:0] : dis_cnt_q;
                if (seq_if.abort_i) begin
                    err_d  = 1'b1;
                    pend_d = '0;
                end
                if (dis_match) state_d = W_ICONS_SEQ_ARB;
            end
            W_ICONS_SEQ_DONE: begin
                state_d = W_ICONS_SEQ_IDLE;
`ifdef W_ICONS_STIM_SEQ_REPEAT_EN
                if (seq_if.repeat_i && !err_q) begin
                    pend_d     = seq_if.ch_req_i;
                    stim_len_d = seq_if.stim_len_i;
                    dis_len_d  = seq_if.dis_len_i;
                    state_d    = W_ICONS_SEQ_ARB;
                end
`endif
            end
            default: state_d = W_ICONS_SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= W_ICONS_SEQ_IDLE;
            pend_q     <= '0;
            ch_sel_q   <= '0;
            last_q     <= IDX_W'(NUM_CH - 1);
            err_q      <= 1'b0;
            stim_len_q <= '0;
            dis_len_q  <= '0;
            stim_cnt_q <= '0;
            dis_cnt_q  <= '0;
            en_stim_q  <= 1'b0;
            en_dis_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            ch_sel_q   <= ch_sel_d;
            last_q     <= last_d;
            err_q      <= err_d;
            stim_len_q <= stim_len_d;
            dis_len_q  <= dis_len_d;
            stim_cnt_q <= stim_cnt_d;
            dis_cnt_q  <= dis_cnt_d;
            en_stim_q  <= (state_d == W_ICONS_SEQ_STIM);
            en_dis_q   <= (state_d == W_ICONS_SEQ_DISCH);
            busy_q     <= (state_d != W_ICONS_SEQ_IDLE);
            done_q     <= (state_d == W_ICONS_SEQ_DONE);
        end
    end

    assign seq_if.en_clk_stim_o      = en_stim_q;
    assign seq_if.en_clk_discharge_o = en_dis_q;
    assign seq_if.ch_sel_o           = ch_sel_q;
    assign seq_if.busy_o             = busy_q;
    assign seq_if.done_o             = done_q;
    assign seq_if.err_o              = err_q;

endmodule

// File: doc/w_icons_stim_seq.md
# w_icons_stim_seq

Round-robin stimulation sequencer in the CLK_REC_I domain. It takes a snapshot of the requesting stimulation channels and serves them one at a time. Each served channel gets a stimulation phase that enables the stim clock divider, then a discharge phase that enables the discharge clock divider. Its outputs drive the `en_clk_stim_i` and `en_clk_discharge_i` inputs of `w_icons_mgmt` and the per-channel select into the stim array.

## Interface
- `NUM_CH`, 8, number of stimulation channels
- `STIM_CNT_W`, 12, width of the stim-phase tick count
- `DIS_CNT_W`, 8, width of the discharge-phase tick count
- `clk_i` in 1: CLK_REC_I
- `reset_n_i` in 1: asynchronous, active-low reset
- `start_i` in 1: one-cycle start strobe
- `abort_i` in 1: level; err_stim or STIM_XEN deasserted
- `ch_req_i` in NUM_CH: channels requesting stimulation (synced stim_mask_en)
- `stim_len_i` in STIM_CNT_W: stim ticks per channel
- `dis_len_i` in DIS_CNT_W: discharge ticks per channel
- `stim_tick_i` in 1: one-cycle strobe per clk_stim period
- `dis_tick_i` in 1: one-cycle strobe per clk_discharge period
- `en_clk_stim_o` out 1: stim divider enable
- `en_clk_discharge_o` out 1: discharge divider enable
- `ch_sel_o` out NUM_CH: one-hot active channel
- `busy_o` out 1: high when not IDLE
- `done_o` out 1: one-cycle pulse at round end
- `err_o` out 1: sticky abort flag

## Operation
- States: IDLE, ARB, STIM, DISCH, DONE.
- **IDLE, start_i=1:** snapshot `ch_req_i`, `stim_len_i` and `dis_len_i`; clear `err_o`; go to ARB.
- **start_i outside IDLE:** ignored; the snapshot is not refreshed.
- **ARB:**
  - Pending mask empty: go to DONE.
  - Otherwise grant the first pending bit strictly after the last granted index, wrapping from NUM_CH-1 to 0. The last-granted pointer is NUM_CH-1 after reset, so channel 0 has priority first.
  - Load `ch_sel_o` with the grant, clear that bit in the pending mask, go to STIM.
- **STIM:** `en_clk_stim_o`=1. Count `stim_tick_i`; when the count equals the snapshot `stim_len`, go to DISCH. If `stim_len`=0, STIM lasts exactly one cycle with the enable high.
- **DISCH:** `en_clk_discharge_o`=1. Count `dis_tick_i` up to the snapshot `dis_len`, then go to ARB. If `dis_len`=0, DISCH lasts one cycle.
- **DONE:** `done_o`=1 for one cycle, `ch_sel_o` cleared, go to IDLE.
- **abort_i=1 in ARB or STIM:** set `err_o`, clear the pending mask, go to DISCH with `ch_sel_o` held. The full discharge runs, then ARB, then DONE.
- **abort_i in DISCH:** set `err_o` and clear the pending mask; discharge is never truncated.
- **abort_i in IDLE:** no effect.
- **Counters:** reset on every state entry; they saturate and cannot wrap.
- **Reset values:** every output 0, state IDLE.
- **Reset asserted mid-operation:** enables drop asynchronously.

## Timing
- All outputs are registered.
- Relative to the start_i edge: ARB at cycle +1, STIM at +2. `en_clk_stim_o` and `ch_sel_o` are valid from cycle +2.
- A tick arriving in the same cycle as the count match is consumed; the state changes on the next edge.
- Between channels: DISCH → ARB → STIM, which leaves 1 cycle with both enables low.
- `en_clk_stim_o` and `en_clk_discharge_o` are never both high.
- abort_i sampled in STIM at edge N: `en_clk_stim_o` is low and `en_clk_discharge_o` is high after edge N.

## Configuration
- `W_ICONS_STIM_SEQ_REPEAT_EN` defined:
  - Adds input `repeat_i`.
  - In DONE with `repeat_i`=1 and `err_o`=0, re-snapshot the inputs and go to ARB instead of IDLE. `done_o` still pulses for one cycle.
- `W_ICONS_STIM_SEQ_REPEAT_EN` undefined: the port is absent and DONE always goes to IDLE.

## Structure
- The shared package holds:
  - state encodings (`W_ICONS_SEQ_IDLE` through `W_ICONS_SEQ_DONE`, 3 bits)
  - default `NUM_CH`, `STIM_CNT_W` and `DIS_CNT_W` constants.
- Sub-module `w_icons_rr_arb`:
  - Purely combinational.
  - Inputs: pending mask and last-granted pointer.
  - Outputs: one-hot grant, grant index and valid.

## Test plan
- `ch_req`=8'b0000_0101, stim_len=3, dis_len=2, continuous ticks:
  - `ch_sel` is 0x01 for 3 ticks, then discharge for 2 ticks, 1 gap cycle, then 0x04.
  - `done_o` pulses once and `err_o`=0.
- `ch_req`=0 with start_i: `done_o` pulses at cycle +2 and neither enable ever asserts.
- abort_i during STIM of channel 0 with `ch_req`=0xFF:
  - Immediate switch to DISCH for the full dis_len; no other channel is served.
  - `err_o`=1 and stays high until the next start_i.
- stim_len=0, dis_len=0, `ch_req`=0x80:
  - STIM lasts 1 cycle, then DISCH lasts 1 cycle, then DONE.
  - `ch_sel`=0x80 throughout.
- Start_i held high during STIM with `ch_req_i` changed: no effect on the active round.
- reset_n_i pulsed low during DISCH: all outputs go to 0 immediately; after release, state is IDLE and channel 0 has priority again.
